mem_controller_write_buffer: RTL and testbench

MEM_CONTROLLER_WRITE_BUFFER -- requirements
Module: mem_controller_write_buffer

---
 rtl/mem_controller_write_buffer_pkg.sv | 34 +++
 rtl/mem_controller_write_buffer.sv | 160 ++++++++++++++++
 tb/tb_mem_controller_write_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_write_buffer_pkg.sv
// Shared memory-side types for the write buffer: RAM status, drain FSM states,
// buffer entry layout and sizing constants.
package mem_controller_write_buffer_pkg;

  localparam int MEM_CONTROLLER_WRITE_BUFFER_DEPTH     = 8;
  localparam int MEM_CONTROLLER_LOG_WRITE_BUFFER_DEPTH = 3;
  localparam int BLOCK_ADDR_SPACE_WIDTH                = 29;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    WB_IDLE = 2'b00,
    WB_WR0  = 2'b01,
    WB_WR1  = 2'b10
  } wb_drain_state_t;

  typedef struct packed {
    logic                              valid;
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] addr;
    logic [1:0][31:0]                  data;
  } wb_entry_t;

  // Byte address of one word of a two-word block.
  function automatic logic [31:0] wb_byte_addr(input logic [BLOCK_ADDR_SPACE_WIDTH-1:0] blk,
                                               input logic word_sel);
    return {blk, word_sel, 2'b00};
  endfunction

endpackage

// File: rtl/mem_controller_write_buffer.sv
// Circular write buffer between cache writebacks and RAM: coalesces repeated
// blocks, forwards buffered data to reads, drains one block as two RAM writes.
module mem_controller_write_buffer
  import mem_controller_write_buffer_pkg::*;
#(
  parameter int DEPTH     = MEM_CONTROLLER_WRITE_BUFFER_DEPTH,
  parameter int LOG_DEPTH = MEM_CONTROLLER_LOG_WRITE_BUFFER_DEPTH
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              wb_valid,
  output logic                              wb_ready,
  input  logic [BLOCK_ADDR_SPACE_WIDTH-1:0] wb_block_addr,
  input  logic [1:0][31:0]                  wb_data,
  input  logic                              rd_check_valid,
  input  logic [BLOCK_ADDR_SPACE_WIDTH-1:0] rd_check_block_addr,
  output logic                              rd_check_hit,
  output logic [1:0][31:0]                  rd_check_data,
  output logic                              ram_WEN,
  output logic [31:0]                       ram_addr,
  output logic [31:0]                       ram_store,
  input  ramstate_t                         ramstate,
  output logic                              empty,
  output logic                              full
);

  wb_entry_t             entries_r [DEPTH];
  logic [LOG_DEPTH-1:0]  head_r;
  logic [LOG_DEPTH-1:0]  tail_r;
  logic [LOG_DEPTH:0]    count_r;
  wb_drain_state_t       state_r;
  wb_drain_state_t       state_next_s;

  logic                  accept_s;
  logic                  alloc_s;
  logic                  draining_s;
  logic                  drain_done_s;
  logic                  coal_hit_s;
  logic [LOG_DEPTH-1:0]  coal_idx_s;

  function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
    return (p == LOG_DEPTH'(DEPTH-1)) ? {LOG_DEPTH{1'b0}} : p + {{(LOG_DEPTH-1){1'b0}}, 1'b1};
  endfunction

  assign empty        = (count_r == {(LOG_DEPTH+1){1'b0}});
  assign full         = (count_r == (LOG_DEPTH+1)'(DEPTH));
  assign wb_ready     = !full;
  assign accept_s     = wb_valid && wb_ready;
  assign draining_s   = (state_r != WB_IDLE);
  assign drain_done_s = (state_r == WB_WR1) && (ramstate == ACCESS);
  assign alloc_s      = accept_s && !coal_hit_s;

  // Coalesce target search; the entry being written to RAM is never a target.
  always_comb begin
    coal_hit_s = 1'b0;
    coal_idx_s = {LOG_DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_r[i].valid && (entries_r[i].addr == wb_block_addr) &&
          !(draining_s && (LOG_DEPTH'(i) == head_r))) begin
        coal_hit_s = 1'b1;
        coal_idx_s = LOG_DEPTH'(i);
      end else begin
        coal_hit_s = coal_hit_s;
      end
    end
  end

  // Read forwarding; a newer non-draining copy of the block wins over the draining one.
  always_comb begin
    rd_check_hit  = 1'b0;
    rd_check_data = {64{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_check_valid && entries_r[i].valid && (entries_r[i].addr == rd_check_block_addr) &&
          (!rd_check_hit || !(draining_s && (LOG_DEPTH'(i) == head_r)))) begin
        rd_check_hit  = 1'b1;
        rd_check_data = entries_r[i].data;
      end else begin
        rd_check_hit = rd_check_hit;
      end
    end
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= {$bits(wb_entry_t){1'b0}};
      end
      head_r  <= {LOG_DEPTH{1'b0}};
      tail_r  <= {LOG_DEPTH{1'b0}};
      count_r <= {(LOG_DEPTH+1){1'b0}};
    end else begin
      if (accept_s && coal_hit_s) begin
        entries_r[coal_idx_s].data <= wb_data;
      end else if (alloc_s) begin
        entries_r[tail_r].valid <= 1'b1;
        entries_r[tail_r].addr  <= wb_block_addr;
        entries_r[tail_r].data  <= wb_data;
        tail_r                  <= ptr_inc(tail_r);
      end
      if (drain_done_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= ptr_inc(head_r);
      end
      case ({alloc_s, drain_done_s})
        2'b10:   count_r <= count_r + {{LOG_DEPTH{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{LOG_DEPTH{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= WB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Drain FSM next state and RAM port; BUSY/FREE/ERROR hold the current word.
  always_comb begin
    state_next_s = state_r;
    ram_WEN      = 1'b0;
    ram_addr     = 32'h0000_0000;
    ram_store    = 32'h0000_0000;
    case (state_r)
      WB_IDLE: begin
        if (!empty) begin
          state_next_s = WB_WR0;
        end else begin
          state_next_s = WB_IDLE;
        end
      end
      WB_WR0: begin
        ram_WEN   = 1'b1;
        ram_addr  = wb_byte_addr(entries_r[head_r].addr, 1'b0);
        ram_store = entries_r[head_r].data[0];
        if (ramstate == ACCESS) begin
          state_next_s = WB_WR1;
        end else begin
          state_next_s = WB_WR0;
        end
      end
      WB_WR1: begin
        ram_WEN   = 1'b1;
        ram_addr  = wb_byte_addr(entries_r[head_r].addr, 1'b1);
        ram_store = entries_r[head_r].data[1];
        if (ramstate == ACCESS) begin
          state_next_s = WB_IDLE;
        end else begin
          state_next_s = WB_WR1;
        end
      end
      default: state_next_s = WB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_controller_write_buffer.sv
// Directed bench for mem_controller_write_buffer: drain sequencing, full
// back-pressure, coalescing, read forwarding, RAM error hold and reset.
module tb_mem_controller_write_buffer;
  import mem_controller_write_buffer_pkg::*;

  logic                              CLK;
  logic                              nRST;
  logic                              wb_valid;
  logic                              wb_ready;
  logic [BLOCK_ADDR_SPACE_WIDTH-1:0] wb_block_addr;
  logic [1:0][31:0]                  wb_data;
  logic                              rd_check_valid;
  logic [BLOCK_ADDR_SPACE_WIDTH-1:0] rd_check_block_addr;
  logic                              rd_check_hit;
  logic [1:0][31:0]                  rd_check_data;
  logic                              ram_WEN;
  logic [31:0]                       ram_addr;
  logic [31:0]                       ram_store;
  ramstate_t                         ramstate;
  logic                              empty;
  logic                              full;

  int tests = 0;
  int fails = 0;

  mem_controller_write_buffer dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .wb_valid            (wb_valid),
    .wb_ready            (wb_ready),
    .wb_block_addr       (wb_block_addr),
    .wb_data             (wb_data),
    .rd_check_valid      (rd_check_valid),
    .rd_check_block_addr (rd_check_block_addr),
    .rd_check_hit        (rd_check_hit),
    .rd_check_data       (rd_check_data),
    .ram_WEN             (ram_WEN),
    .ram_addr            (ram_addr),
    .ram_store           (ram_store),
    .ramstate            (ramstate),
    .empty               (empty),
    .full                (full)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [28:0] a, input logic [31:0] w0, input logic [31:0] w1);
    wb_valid      = 1'b1;
    wb_block_addr = a;
    wb_data[0]    = w0;
    wb_data[1]    = w1;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    nRST                = 1'b0;
    wb_valid            = 1'b0;
    wb_block_addr       = 29'h0;
    wb_data             = 64'h0;
    rd_check_valid      = 1'b1;
    rd_check_block_addr = 29'h0;
    ramstate            = FREE;
    #3;
    chk("rst_wb_ready", 64'(wb_ready), 64'h1);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_wen", 64'(ram_WEN), 64'h0);
    chk("rst_addr", 64'(ram_addr), 64'h0);
    chk("rst_store", 64'(ram_store), 64'h0);
    chk("rst_hit", 64'(rd_check_hit), 64'h0);
    #4;
    nRST = 1'b1;
    cyc();

    // Single block drained with ACCESS every cycle.
    ramstate = ACCESS;
    offer(29'h10, 32'hAAAA0001, 32'hBBBB0002);
    rd_check_block_addr = 29'h10;
    #1;
    chk("fwd_same_cycle_hit", 64'(rd_check_hit), 64'h0);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("t1_not_empty", 64'(empty), 64'h0);
    chk("t1_idle_wen", 64'(ram_WEN), 64'h0);
    chk("t1_fwd_hit", 64'(rd_check_hit), 64'h1);
    chk("t1_fwd_data", 64'(rd_check_data), 64'hBBBB0002_AAAA0001);
    cyc();
    chk("t1_wr0_wen", 64'(ram_WEN), 64'h1);
    chk("t1_wr0_addr", 64'(ram_addr), 64'h80);
    chk("t1_wr0_store", 64'(ram_store), 64'hAAAA0001);
    cyc();
    chk("t1_wr1_addr", 64'(ram_addr), 64'h84);
    chk("t1_wr1_store", 64'(ram_store), 64'hBBBB0002);
    cyc();
    chk("t1_done_wen", 64'(ram_WEN), 64'h0);
    chk("t1_done_empty", 64'(empty), 64'h1);
    chk("t1_done_hit", 64'(rd_check_hit), 64'h0);

    // Fill all eight slots while RAM is busy.
    ramstate = BUSY;
    for (int i = 0; i < 8; i++) begin
      offer(29'h100 + 29'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      cyc();
    end
    offer(29'h200, 32'h9, 32'h9);
    rd_check_block_addr = 29'h200;
    #1;
    chk("t2_full", 64'(full), 64'h1);
    chk("t2_wb_ready", 64'(wb_ready), 64'h0);
    chk("t2_head_addr", 64'(ram_addr), 64'h800);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("t2_ninth_not_taken_hit", 64'(rd_check_hit), 64'h0);
    chk("t2_still_full", 64'(full), 64'h1);
    ramstate = ACCESS;
    cyc();
    chk("t2_wr1_addr", 64'(ram_addr), 64'h804);
    chk("t2_wr1_store", 64'(ram_store), 64'h2000);
    cyc();
    ramstate = BUSY;
    #1;
    chk("t2_slot_freed_full", 64'(full), 64'h0);
    chk("t2_slot_freed_ready", 64'(wb_ready), 64'h1);

    // Coalescing behind a busy head, plus a rewrite of the draining block.
    pulse_reset();
    chk("t3_reset_empty", 64'(empty), 64'h1);
    offer(29'h30, 32'h30, 32'h31);
    cyc();
    offer(29'h20, 32'h1, 32'h11);
    cyc();
    offer(29'h20, 32'h2, 32'h22);
    cyc();
    offer(29'h30, 32'h77, 32'h78);
    rd_check_block_addr = 29'h20;
    #1;
    chk("t3_fwd_hit", 64'(rd_check_hit), 64'h1);
    chk("t3_fwd_data", 64'(rd_check_data), 64'h00000022_00000002);
    rd_check_block_addr = 29'h21;
    #1;
    chk("t3_miss_hit", 64'(rd_check_hit), 64'h0);
    chk("t3_head_addr", 64'(ram_addr), 64'h180);
    ramstate = ACCESS;
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("t3_head_wr1_addr", 64'(ram_addr), 64'h184);
    chk("t3_head_old_store", 64'(ram_store), 64'h31);
    cyc();
    chk("t3_idle_not_empty", 64'(empty), 64'h0);
    cyc();
    chk("t3_coal_wr0_addr", 64'(ram_addr), 64'h100);
    chk("t3_coal_wr0_store", 64'(ram_store), 64'h2);
    cyc();
    chk("t3_coal_wr1_store", 64'(ram_store), 64'h22);
    cyc();
    chk("t3_one_left", 64'(empty), 64'h0);
    cyc();
    chk("t3_realloc_addr", 64'(ram_addr), 64'h180);
    chk("t3_realloc_store0", 64'(ram_store), 64'h77);
    cyc();
    chk("t3_realloc_store1", 64'(ram_store), 64'h78);
    cyc();
    chk("t3_final_empty", 64'(empty), 64'h1);

    // ERROR holds WR0; reset in WR1 drops everything at once.
    ramstate = ERROR;
    offer(29'h40, 32'h4000, 32'h4001);
    cyc();
    wb_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t4_err_hold_addr", 64'(ram_addr), 64'h200);
      chk("t4_err_hold_store", 64'(ram_store), 64'h4000);
      cyc();
    end
    chk("t4_err_hold_wen", 64'(ram_WEN), 64'h1);
    ramstate = ACCESS;
    cyc();
    ramstate = BUSY;
    #1;
    chk("t4_wr1_addr", 64'(ram_addr), 64'h204);
    rd_check_block_addr = 29'h40;
    nRST = 1'b0;
    #1;
    chk("t4_rst_wen", 64'(ram_WEN), 64'h0);
    chk("t4_rst_addr", 64'(ram_addr), 64'h0);
    chk("t4_rst_store", 64'(ram_store), 64'h0);
    chk("t4_rst_empty", 64'(empty), 64'h1);
    chk("t4_rst_ready", 64'(wb_ready), 64'h1);
    chk("t4_rst_hit", 64'(rd_check_hit), 64'h0);
    nRST = 1'b1;
    cyc();
    cyc();
    chk("t4_data_lost_wen", 64'(ram_WEN), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
